// File: rtl/csr_intc_if.sv
// csr_intc_if: CSR access, interrupt lines and redirect outputs between the core and csr_intc
interface csr_intc_if #(parameter int NIRQ = 4);
    logic [31:0] pc;
    logic ei_n;
    logic ti_n;
    logic [NIRQ-1:0] lirq_n;
    logic ecall;
    logic ebreak;
    logic mret;
    logic [1:0] csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic trap_flag;
    logic [31:0] trap_addr;
    modport master(
        output pc, ei_n, ti_n, lirq_n, ecall, ebreak, mret, csr_cmd, csr_addr, wdata,
        input rdata, trap_flag, trap_addr
    );
    modport slave(
        input pc, ei_n, ti_n, lirq_n, ecall, ebreak, mret, csr_cmd, csr_addr, wdata,
        output rdata, trap_flag, trap_addr
    );
endinterface

// File: rtl/csr_intc.sv
// csr_intc: machine-mode CSR file with interrupt controller, trap entry/mret redirect and cycle counter
module csr_intc #(
    parameter int NIRQ = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter bit VEC_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    csr_intc_if.slave bus
);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;
    localparam logic [31:0] MIE_MASK = 32'h0000_0880 | (((32'h1 << NIRQ) - 32'h1) << 16);
    logic [0:0] state;
    logic mst_mie, mst_mpie;
    logic [31:0] mie_r, mtvec, mscratch, mepc, mcause, mtval, taddr;
    logic [63:0] mcycle;
    logic [NIRQ+1:0] sync1, sync2;
    logic [31:0] mip, pending, old, nv, cause, base, target;
    logic [4:0] lcause;
    logic run, exc, irq, take, we;
    function automatic logic [31:0] tvec_legal(input logic [31:0] v);
        return {v[31:2], 1'b0, VEC_EN && v[1:0] == 2'b01};
    endfunction
    always_comb begin
        mip = '0;
        mip[7] = ~sync2[NIRQ];
        mip[11] = ~sync2[NIRQ+1];
        mip[16 +: NIRQ] = ~sync2[NIRQ-1:0];
    end
    always_comb begin
        case (bus.csr_addr)
            12'h300: old = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
            12'h304: old = mie_r;
            12'h305: old = mtvec;
            12'h340: old = mscratch;
            12'h341: old = mepc;
            12'h342: old = mcause;
            12'h343: old = mtval;
            12'h344: old = mip;
            12'hB00: old = mcycle[31:0];
            12'hB80: old = mcycle[63:32];
            default: old = '0;
        endcase
    end
    assign run = state == RUN;
    assign pending = mie_r & mip;
    assign exc = bus.ecall | bus.ebreak;
    assign irq = mst_mie & |pending;
    // exceptions beat mret, mret beats a pending interrupt
    assign take = run & (exc | (~bus.mret & irq));
    assign we = run & ~take & ~bus.mret & |bus.csr_cmd & (bus.csr_cmd == 2'd1 | |bus.wdata);
    assign nv = bus.csr_cmd == 2'd1 ? bus.wdata : bus.csr_cmd == 2'd2 ? old | bus.wdata : old & ~bus.wdata;
    always_comb begin
        lcause = 5'd16;
        for (int i = NIRQ - 1; i >= 0; i--) if (pending[16 + i]) lcause = 5'(16 + i);
    end
    assign cause = bus.ecall ? 32'd11 : bus.ebreak ? 32'd3 : pending[11] ? 32'h8000_000B :
                   pending[7] ? 32'h8000_0007 : {1'b1, 26'b0, lcause};
    assign base = {mtvec[31:2], 2'b00};
    assign target = (~exc & mtvec[0]) ? base + {25'b0, cause[4:0], 2'b00} : base;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            state <= RUN;
            taddr <= '0;
            mst_mie <= 1'b0;
            mst_mpie <= 1'b0;
            mie_r <= '0;
            mtvec <= tvec_legal(RESET_VEC);
            mscratch <= '0;
            mepc <= '0;
            mcause <= '0;
            mtval <= '0;
            mcycle <= '0;
        end else begin
            sync1 <= {bus.ei_n, bus.ti_n, bus.lirq_n};
            sync2 <= sync1;
            state <= (take | (run & bus.mret)) ? REDIRECT : RUN;
            mcycle <= mcycle + 64'd1;
            if (take) begin
                taddr <= target;
                mepc <= bus.pc & 32'hFFFF_FFFC;
                mcause <= cause;
                mtval <= '0;
                mst_mpie <= mst_mie;
                mst_mie <= 1'b0;
            end else if (run & bus.mret) begin
                taddr <= mepc;
                mst_mie <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (we) begin
                case (bus.csr_addr)
                    12'h300: begin
                        mst_mie <= nv[3];
                        mst_mpie <= nv[7];
                    end
                    12'h304: mie_r <= nv & MIE_MASK;
                    12'h305: mtvec <= tvec_legal(nv);
                    12'h340: mscratch <= nv;
                    12'h341: mepc <= nv & 32'hFFFF_FFFC;
                    12'h342: mcause <= nv;
                    12'h343: mtval <= nv;
                    12'hB00: mcycle <= {mcycle[63:32], nv};
                    12'hB80: mcycle <= {nv, mcycle[31:0]};
                    default: ;
                endcase
            end
        end
    end
    assign bus.rdata = old;
    assign bus.trap_flag = state == REDIRECT;
    assign bus.trap_addr = taddr;
endmodule

// File: tb/tb_csr_intc.sv
// tb_csr_intc: randomized scoreboard bench for csr_intc against a behavioural CSR/trap model
module tb_csr_intc;
    localparam int NIRQ = 4;
    localparam logic [31:0] RV = 32'h0000_0200;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    csr_intc_if #(.NIRQ(NIRQ)) bus();
    csr_intc #(.NIRQ(NIRQ), .RESET_VEC(RV), .VEC_EN(1'b1)) dut(.clk(clk), .rst(rst), .bus(bus));
    typedef struct { int due; logic [31:0] addr; } exp_t;
    exp_t sq[$];
    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] m_mst, m_mie, m_tvec, m_scr, m_epc, m_cause, m_tval;
    logic [63:0] m_cyc;
    logic m_redir;
    logic [31:0] m_hist[$];
    logic [31:0] last_rd, last_taddr;
    logic last_flag;
    logic [11:0] addrs[12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'hB00, 12'hB80, 12'h301, 12'h7C0};
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask
    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mst;
            12'h304: return m_mie;
            12'h305: return m_tvec;
            12'h340: return m_scr;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_hist[0];
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            default: return 32'h0;
        endcase
    endfunction
    function automatic logic [31:0] cur_irq();
        logic [31:0] v = 32'h0;
        v[11] = ~bus.ei_n;
        v[7] = ~bus.ti_n;
        for (int i = 0; i < NIRQ; i++) v[16 + i] = ~bus.lirq_n[i];
        return v;
    endfunction
    task automatic m_reset();
        m_mst = 32'h1800; m_mie = 0; m_tvec = RV; m_scr = 0; m_epc = 0; m_cause = 0; m_tval = 0;
        m_cyc = 0; m_redir = 0;
        m_hist = '{32'h0, 32'h0};
        sq.delete();
    endtask
    // one clock of the reference model, evaluated from the inputs presented this cycle
    task automatic m_step();
        logic [31:0] pend, old, nv, cause, tgt;
        int prio[NIRQ + 2];
        bit found = 0, wr = 0;
        pend = m_mie & m_hist[0];
        old = m_read(bus.csr_addr);
        prio[0] = 11;
        prio[1] = 7;
        for (int i = 0; i < NIRQ; i++) prio[2 + i] = 16 + i;
        if (m_redir) m_redir = 0;
        else if (bus.ecall || bus.ebreak || (!bus.mret && m_mst[3] && pend != 0)) begin
            if (bus.ecall) cause = 11;
            else if (bus.ebreak) cause = 3;
            else begin
                cause = 0;
                for (int k = 0; k < NIRQ + 2; k++)
                    if (!found && pend[prio[k]]) begin
                        cause = 32'h8000_0000 | prio[k];
                        found = 1;
                    end
            end
            tgt = m_tvec & ~32'h3;
            if (cause[31] && m_tvec[1:0] == 2'b01) tgt = tgt + 4 * (cause & 32'h1F);
            sq.push_back('{cyc + 1, tgt});
            m_epc = bus.pc & ~32'h3;
            m_cause = cause;
            m_tval = 0;
            m_mst = 32'h1800 | (m_mst[3] ? 32'h80 : 32'h0);
            m_redir = 1;
        end else if (bus.mret) begin
            sq.push_back('{cyc + 1, m_epc});
            m_mst = 32'h1880 | (m_mst[7] ? 32'h8 : 32'h0);
            m_redir = 1;
        end else if (bus.csr_cmd != 0 && (bus.csr_cmd == 1 || bus.wdata != 0)) begin
            nv = bus.csr_cmd == 1 ? bus.wdata : bus.csr_cmd == 2 ? (old | bus.wdata) : (old & ~bus.wdata);
            case (bus.csr_addr)
                12'h300: m_mst = (nv & 32'h88) | 32'h1800;
                12'h304: m_mie = nv & (32'h880 | (((32'h1 << NIRQ) - 1) << 16));
                12'h305: m_tvec = (nv & ~32'h3) | (nv[1:0] == 2'b01 ? 32'h1 : 32'h0);
                12'h340: m_scr = nv;
                12'h341: m_epc = nv & ~32'h3;
                12'h342: m_cause = nv;
                12'h343: m_tval = nv;
                12'hB00: begin m_cyc[31:0] = nv; wr = 1; end
                12'hB80: begin m_cyc[63:32] = nv; wr = 1; end
                default: ;
            endcase
        end
        if (!wr) m_cyc = m_cyc + 1;
        m_hist.push_back(cur_irq());
        void'(m_hist.pop_front());
    endtask
    task automatic tick();
        @(negedge clk);
        last_rd = bus.rdata;
        last_flag = bus.trap_flag;
        last_taddr = bus.trap_addr;
        chk("rdata", bus.rdata, m_read(bus.csr_addr));
        m_step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.ecall = 0; bus.ebreak = 0; bus.mret = 0; bus.csr_cmd = 0; bus.csr_addr = 0; bus.wdata = 0;
    endtask
    task automatic csr(input logic [1:0] cmd, input logic [11:0] a, input logic [31:0] d);
        bus.csr_cmd = cmd; bus.csr_addr = a; bus.wdata = d;
        tick();
        idle();
    endtask
    task automatic rd(input logic [11:0] a);
        bus.csr_addr = a;
        tick();
        idle();
    endtask
    always @(negedge clk) if (!rst) begin
        if (sq.size() > 0 && sq[0].due <= cyc) begin
            chk("trap_flag_pulse", {31'b0, bus.trap_flag}, 32'h1);
            chk("trap_addr", bus.trap_addr, sq[0].addr);
            void'(sq.pop_front());
        end else chk("trap_flag_idle", {31'b0, bus.trap_flag}, 32'h0);
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [NIRQ+1:0] iv;
        idle();
        bus.pc = 0; bus.ei_n = 1; bus.ti_n = 1; bus.lirq_n = '1;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_trap_flag", {31'b0, bus.trap_flag}, 32'h0);
        chk("rst_trap_addr", bus.trap_addr, 32'h0);
        rst = 0;
        foreach (addrs[k]) rd(addrs[k]);
        rd(12'h300);
        chk("rst_mstatus", last_rd, 32'h0000_1800);
        rd(12'h305);
        chk("rst_mtvec", last_rd, RV);
        // mscratch set then cleared
        csr(2'd1, 12'h340, 32'hA5A5_A5A5);
        csr(2'd3, 12'h340, 32'h0000_FFFF);
        rd(12'h340);
        chk("csrrc_mscratch", last_rd, 32'hA5A5_0000);
        // external interrupt through vectored mtvec
        csr(2'd1, 12'h305, 32'h0000_1001);
        csr(2'd1, 12'h304, 32'h0000_0800);
        csr(2'd1, 12'h300, 32'h0000_0008);
        bus.ei_n = 0;
        tick();
        tick();
        rd(12'h344);
        chk("mip_meip_sync", last_rd & 32'h800, 32'h800);
        tick();
        chk("mei_flag", {31'b0, last_flag}, 32'h1);
        chk("mei_vector", last_taddr, 32'h0000_102C);
        bus.ei_n = 1;
        rd(12'h342);
        chk("mei_mcause", last_rd, 32'h8000_000B);
        rd(12'h300);
        chk("mei_mstatus", last_rd, 32'h0000_1880);
        // ecall beats a simultaneous CSR write
        csr(2'd1, 12'h340, 32'h0000_5555);
        bus.pc = 32'h0000_0104; bus.ecall = 1; bus.csr_cmd = 1; bus.csr_addr = 12'h340; bus.wdata = 32'hDEAD_BEEF;
        tick();
        idle();
        tick();
        chk("ecall_target", last_taddr, 32'h0000_1000);
        rd(12'h341);
        chk("ecall_mepc", last_rd, 32'h0000_0104);
        rd(12'h342);
        chk("ecall_mcause", last_rd, 32'h0000_000B);
        rd(12'h340);
        chk("ecall_mscratch", last_rd, 32'h0000_5555);
        // timer beats local line 0; local line taken after mret
        bus.ti_n = 0; bus.lirq_n[0] = 0;
        csr(2'd1, 12'h304, 32'h0001_0080);
        csr(2'd2, 12'h300, 32'h0000_0008);
        tick();
        tick();
        rd(12'h342);
        chk("mti_mcause", last_rd, 32'h8000_0007);
        bus.ti_n = 1;
        repeat (3) tick();
        bus.mret = 1;
        tick();
        idle();
        repeat (3) tick();
        rd(12'h342);
        chk("local0_mcause", last_rd, 32'h8000_0010);
        bus.lirq_n = '1;
        // low half of the cycle counter wraps into the high half
        csr(2'd1, 12'hB80, 32'h0);
        csr(2'd1, 12'hB00, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00);
        chk("mcycle_wrap_lo", last_rd, 32'h0);
        rd(12'hB80);
        chk("mcycle_wrap_hi", last_rd, 32'h1);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bus.pc = $urandom;
            bus.ecall = ($urandom_range(0, 24) == 0);
            bus.ebreak = ($urandom_range(0, 24) == 0);
            bus.mret = ($urandom_range(0, 19) == 0);
            bus.csr_cmd = 2'($urandom_range(0, 3));
            bus.csr_addr = addrs[$urandom_range(0, 11)];
            bus.wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin
                iv = (NIRQ + 2)'($urandom);
                {bus.ei_n, bus.ti_n, bus.lirq_n} = iv;
            end
            tick();
        end
        idle();
        // reset in the middle of a redirect pulse
        bus.ecall = 1;
        tick();
        idle();
        chk("pre_rst_flag", {31'b0, bus.trap_flag}, 32'h1);
        #2 rst = 1;
        #1;
        chk("async_rst_flag", {31'b0, bus.trap_flag}, 32'h0);
        chk("async_rst_addr", bus.trap_addr, 32'h0);
        bus.ei_n = 1; bus.ti_n = 1; bus.lirq_n = '1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 0;
        foreach (addrs[k]) rd(addrs[k]);
        repeat (3) tick();
        chk("scoreboard_drained", sq.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_intc.md
CSR_INTC -- requirements
Module: csr_intc

Interface
REQ-001 SHALL have parameter NIRQ, default 4, meaning the number of local external interrupt lines (legal range 1..16).
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning the mtvec reset value.
REQ-003 SHALL have parameter VEC_EN, default 1; 1 allows vectored mtvec mode, 0 forces direct mode.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pc  in  32  address of the current instruction.
REQ-007 ei_n  in  1  machine external interrupt, active low, asynchronous.
REQ-008 ti_n  in  1  machine timer interrupt, active low, asynchronous.
REQ-009 lirq_n  in  NIRQ  local interrupts, active low, asynchronous.
REQ-010 ecall, ebreak, mret  in  1 each  single-cycle instruction strobes, active high.
REQ-011 csr_cmd  in  2  0=none, 1=csrrw, 2=csrrs, 3=csrrc.
REQ-012 csr_addr  in  12  CSR address.
REQ-013 wdata  in  32  CSR write operand (rs1 or zero-extended immediate).
REQ-014 rdata  out  32  combinational read of csr_addr (pre-write value).
REQ-015 trap_flag  out  1  registered one-cycle redirect pulse.
REQ-016 trap_addr  out  32  registered redirect target, valid while trap_flag=1.

Function
REQ-017 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, mcycleh 0xB80.
REQ-018 Unimplemented addresses SHALL read 0; writes to them SHALL be ignored.
REQ-019 csrrw SHALL write wdata; csrrs SHALL write old|wdata; csrrc SHALL write old&~wdata; csrrs/csrrc with wdata=0 SHALL NOT write.
REQ-020 mstatus: only MIE[3] and MPIE[7] SHALL be writable; MPP[12:11] SHALL read 2'b11; all other bits SHALL read 0.
REQ-021 mie: writable bits SHALL be MTIE[7], MEIE[11] and bits 16..16+NIRQ-1; all other bits SHALL read 0.
REQ-022 mip SHALL be read-only: MTIP[7]=synced ~ti_n, MEIP[11]=synced ~ei_n, bit 16+i=synced ~lirq_n[i].
REQ-023 Each interrupt input SHALL pass through a two-flop synchroniser; mip SHALL reflect an input change 2 cycles later.
REQ-024 mepc and mtvec bits[1:0] SHALL handle as follows: mepc[1:0] SHALL read 0; mtvec[1:0] SHALL hold the mode (0 direct, 1 vectored), values 2/3 SHALL store as 0, and when VEC_EN=0 the mode bits SHALL be forced to 0.
REQ-025 The mcycle/mcycleh 64-bit counter SHALL increment by 1 every cycle with wrap at 2^64; in a cycle where either half is written, the written half SHALL take the written value and the counter SHALL NOT increment that cycle.
REQ-026 pending = mie & mip; an interrupt SHALL be taken only when mstatus.MIE=1 and pending is nonzero.
REQ-027 Priority SHALL be ecall (cause 11) > ebreak (cause 3) > MEI (0x8000000B) > MTI (0x80000007) > local i, lowest i first (0x80000000|(16+i)); exceptions SHALL be taken regardless of MIE.
REQ-028 On a trap, the following SHALL update at the clock edge: mepc<={pc[31:2],2'b00}, mcause<=cause, mtval<=0, MPIE<=MIE, MIE<=0.
REQ-029 trap_addr SHALL equal {mtvec[31:2],2'b00} for exceptions or direct mode, and {mtvec[31:2],2'b00}+4*cause[4:0] for interrupts in vectored mode.
REQ-030 For mret, trap_addr SHALL equal mepc, and MIE<=MPIE and MPIE<=1.
REQ-031 trap_flag/trap_addr SHALL assert in the cycle after the triggering edge (1-cycle latency) for exactly one cycle.
REQ-032 The block SHALL have two states, RUN and REDIRECT; a trap or mret in RUN SHALL go to REDIRECT; REDIRECT SHALL always return to RUN; in REDIRECT, strobes, csr_cmd and interrupts SHALL be ignored (flushed instruction slot).
REQ-033 On a simultaneous trap and CSR write, the trap SHALL win and the write SHALL be discarded.
REQ-034 On a simultaneous mret and pending interrupt, mret SHALL win; the interrupt SHALL be taken in the first RUN cycle after REDIRECT if still enabled.
REQ-035 On a simultaneous ecall and ebreak, ecall SHALL win.

Reset
REQ-036 On rst=1 the block SHALL asynchronously set mstatus=0x00001800, mie=0, mtvec=RESET_VEC (mode forced 0 if VEC_EN=0), mscratch=mepc=mcause=mtval=0, mcycle=0, synchronisers=inactive, state=RUN, trap_flag=0, trap_addr=0.
REQ-037 Reset asserted mid-REDIRECT SHALL clear trap_flag immediately.

Verification
REQ-038 csrrw 0x340 wdata=0xA5A5A5A5, then csrrc wdata=0x0000FFFF -> rdata of 0x340 reads 0xA5A50000.
REQ-039 mtvec=0x00001001, mie=0x00000800, MIE=1, ei_n low at cycle 0 -> mip[11]=1 at cycle 2; trap_flag=1 with trap_addr=0x0000102C; mcause=0x8000000B; MIE=0, MPIE=1.
REQ-040 ecall at pc=0x00000104 while csrrw 0x340 is issued in the same cycle -> mepc=0x104, mcause=0xB, mscratch unchanged, trap_addr=mtvec base.
REQ-041 ti_n and lirq_n[0] both low, all enabled, MEI inactive -> mcause=0x80000007; after mret and with ti_n deasserted -> next trap mcause=0x80000010.
REQ-042 csrrw 0xB00 wdata=0xFFFFFFFF, mcycleh=0 -> two cycles later mcycle=0x00000000 and mcycleh=0x00000001.
REQ-043 rst pulsed while trap_flag=1 -> trap_flag=0 within the same cycle; all CSRs at their reset values.
